// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared types, constants and access helpers for load_store_unit.
//
// Contents:
//   funct3_e     - RISC-V load/store funct3 encodings (SB/SH/SW alias LB/LH/LW)
//   lsu_state_e  - load_store_unit FSM states
//   BE_*         - base byte-enable patterns, shifted by the address offset
//   access_legal - funct3 legality plus natural-alignment check
//   byte_enable  - byte enables for an access size and offset
//   store_lanes  - store data replicated across every lane of the access size
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } funct3_e;

    // Stores share the signed-load encodings.
    localparam funct3_e SB = LB;
    localparam funct3_e SH = LH;
    localparam funct3_e SW = LW;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // True when funct3 is valid for the direction and the address is
    // naturally aligned for the access size.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (funct3)
            LB:      ok = 1'b1;
            LH:      ok = ~offset[0];
            LW:      ok = (offset == 2'b00);
            LBU:     ok = ~is_store;
            LHU:     ok = ~is_store & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            LB, LBU: be = BE_BYTE << offset;
            LH, LHU: be = BE_HALF << offset;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicating the data means memory picks the right lane with the byte
    // enables alone; no shifter is needed on the write path.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            SB:      lanes = {4{wdata[7:0]}};
            SH:      lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if: groups the execute-stage request/response signals and
// the data-memory req/ack bus of load_store_unit.
//
// Signals (names seen from the load/store unit):
//   req_valid_i/req_ready_o, is_store_i, funct3_i, addr_i, wdata_i, rd_i
//   resp_valid_o, rdata_o, rd_o, err_o, stall_o
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_ack_i,
//   mem_rdata_i
//
// Modports:
//   slave  - the load/store unit itself
//   master - the environment (pipeline and data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  is_store_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [4:0]            rd_i;

    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [4:0]            rd_o;
    logic                  err_o;
    logic                  stall_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, is_store_i, funct3_i, addr_i, wdata_i, rd_i,
        input  mem_ack_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, rdata_o, rd_o, err_o, stall_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, is_store_i, funct3_i, addr_i, wdata_i, rd_i,
        output mem_ack_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, rdata_o, rd_o, err_o, stall_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend: selects the addressed lane of a read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
//
// Ports:
//   i_word    [31:0] word returned by data memory
//   i_offset  [1:0]  byte offset of the access (addr[1:0])
//   i_funct3  [2:0]  load funct3 (LB/LH/LW/LBU/LHU)
//   o_result  [31:0] extended load data
// ---------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    // Halves are aligned, so only offset bit 1 picks the lane.
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LBU:     o_result = {24'd0, w_byte};
            LHU:     o_result = {16'd0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit: memory stage behind the execute-stage ALU. Accepts one
// load/store at a time, performs a single aligned access over a req/ack
// memory handshake and returns extended load data for writeback. Illegal or
// misaligned requests skip memory and complete with err_o set.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - load_store_unit_if.slave: execute-stage request, writeback
//          response, stall and data-memory bus
//
// Parameters:
//   DATA_WIDTH     - data/address width, only 32 is supported
//   TIMEOUT_CYCLES - REQ watchdog limit, used only with LSU_TIMEOUT_EN
//
// Configuration macro:
//   LSU_TIMEOUT_EN - when defined, an access with no ack after
//                    TIMEOUT_CYCLES REQ cycles is aborted with err_o = 1.
//                    When undefined, REQ waits for the ack indefinitely.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("load_store_unit: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
    end

    lsu_state_e            r_state, w_state_d;

    // Request fields captured at accept.
    logic                  r_is_store, w_is_store_d;
    logic [2:0]            r_funct3, w_funct3_d;
    logic [DATA_WIDTH-1:0] r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
    logic [4:0]            r_rd, w_rd_d;

    // Writeback results, updated only on entry to RESP.
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
    logic [4:0]            r_rd_out, w_rd_out_d;
    logic                  r_err, w_err_d;

    logic                  w_ready;
    logic                  w_req_legal;
    logic                  w_tmo_expired;
    logic [31:0]           w_load_data;

    assign w_ready     = (r_state == IDLE);
    assign w_req_legal = access_legal(bus.is_store_i, bus.funct3_i, bus.addr_i[1:0]);

    load_extend u_load_extend (
        .i_word   (bus.mem_rdata_i),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_result (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts REQ cycles already spent; zero outside REQ, so it restarts on
    // every entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != REQ) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires in the last permitted REQ cycle if that cycle brings no ack.
    assign w_tmo_expired = (r_state == REQ) && (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo_expired = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_is_store_d = r_is_store;
        w_funct3_d   = r_funct3;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_rd_d       = r_rd;
        w_rdata_d    = r_rdata;
        w_rd_out_d   = r_rd_out;
        w_err_d      = r_err;

        unique case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    w_is_store_d = bus.is_store_i;
                    w_funct3_d   = bus.funct3_i;
                    w_addr_d     = bus.addr_i;
                    w_wdata_d    = bus.wdata_i;
                    w_rd_d       = bus.rd_i;
                    if (w_req_legal) begin
                        w_state_d = REQ;
                    end else begin
                        // Bad request completes without touching memory.
                        w_state_d  = RESP;
                        w_err_d    = 1'b1;
                        w_rdata_d  = '0;
                        w_rd_out_d = bus.rd_i;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack_i) begin
                    w_state_d  = RESP;
                    w_err_d    = 1'b0;
                    w_rdata_d  = r_is_store ? '0 : w_load_data;
                    w_rd_out_d = r_rd;
                end else if (w_tmo_expired) begin
                    w_state_d  = RESP;
                    w_err_d    = 1'b1;
                    w_rdata_d  = '0;
                    w_rd_out_d = r_rd;
                end
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 5'd0;
            r_rdata    <= '0;
            r_rd_out   <= 5'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_is_store <= w_is_store_d;
            r_funct3   <= w_funct3_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_rd       <= w_rd_d;
            r_rdata    <= w_rdata_d;
            r_rd_out   <= w_rd_out_d;
            r_err      <= w_err_d;
        end
    end

    // Core-side outputs.
    assign bus.req_ready_o  = w_ready;
    assign bus.stall_o      = bus.req_valid_i & ~w_ready;
    assign bus.resp_valid_o = (r_state == RESP);
    assign bus.rdata_o      = r_rdata;
    assign bus.rd_o         = r_rd_out;
    assign bus.err_o        = r_err;

    // Memory-side outputs come straight from state and captured fields, so
    // they hold steady for the whole REQ phase and drop with an async reset.
    assign bus.mem_req_o   = (r_state == REQ);
    assign bus.mem_we_o    = (r_state == REQ) & r_is_store;
    assign bus.mem_be_o    = byte_enable(r_funct3, r_addr[1:0]);
    assign bus.mem_addr_o  = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata_o = store_lanes(r_funct3, r_wdata);

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit: self-checking bench for load_store_unit. Directed cases
// followed by randomized loads/stores, each compared against a behavioural
// model of the access rules. Inputs change and outputs are sampled 1 ns after
// the rising clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_size(input int f3);
        int s;
        case (f3 % 4)
            0:       s = 1;
            1:       s = 2;
            default: s = 4;
        endcase
        return s;
    endfunction

    function automatic bit model_legal(input bit st, input int f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (st && f3 > 2) return 1'b0;
        if (!st && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
        return (off % model_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input int f3, input logic [31:0] a);
        int size;
        int v;
        size = model_size(f3);
        if (size == 4) return 4'hF;
        v = ((1 << size) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] wd);
        int size;
        logic [31:0] r;
        size = model_size(f3);
        if (size == 1)      r = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) r = (wd & 32'hFFFF) * 32'h0001_0001;
        else                r = wd;
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int size;
        int bits;
        longint v;
        size = model_size(f3);
        if (size == 4) return word;
        bits = 8 * size;
        v = longint'(word >> (8 * int'(a[1:0]))) & ((longint'(1) << bits) - 1);
        if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to completion. Entered and left at
    // 1 ns after a rising edge with the unit idle. 'hold' keeps req_valid_i
    // asserted (with a different address) while the access is outstanding.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int delay,
                         input logic [31:0] rword, input bit hold);
        bit legal;
        logic [31:0] exp_rdata;
        legal = model_legal(st, int'(f3), a);
        check("ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.is_store_i  = st;
        bus.funct3_i    = f3;
        bus.addr_i      = a;
        bus.wdata_i     = wd;
        bus.rd_i        = rd;
        tick();
        if (hold) bus.addr_i = a ^ 32'h0000_1000;
        else      bus.req_valid_i = 1'b0;
        if (legal) begin
            for (int c = 0; c <= delay; c++) begin
                check("mem_req", bus.mem_req_o, 1);
                check("mem_addr", bus.mem_addr_o, a & 32'hFFFF_FFFC);
                check("mem_be", bus.mem_be_o, model_be(int'(f3), a));
                check("mem_we", bus.mem_we_o, st);
                if (st) check("mem_wdata", bus.mem_wdata_o, model_wdata(int'(f3), wd));
                check("resp_early", bus.resp_valid_o, 0);
                if (hold) begin
                    check("stall", bus.stall_o, 1);
                    check("ready_busy", bus.req_ready_o, 0);
                end
                if (c == delay) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = rword;
                    bus.req_valid_i = 1'b0;
                end else begin
                    bus.mem_rdata_i = $urandom;
                end
                tick();
            end
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = $urandom;
            exp_rdata = st ? 32'd0 : model_load(int'(f3), a, rword);
        end else begin
            exp_rdata = 32'd0;
        end
        check("resp_valid", bus.resp_valid_o, 1);
        check("resp_err", bus.err_o, !legal);
        check("resp_rdata", bus.rdata_o, exp_rdata);
        check("resp_rd", bus.rd_o, rd);
        check("no_mem_in_resp", bus.mem_req_o, 0);
        tick();
        check("resp_one_cycle", bus.resp_valid_o, 0);
        check("ready_after", bus.req_ready_o, 1);
        check("rdata_hold", bus.rdata_o, exp_rdata);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.is_store_i  = 1'b0;
        bus.funct3_i    = 3'd0;
        bus.addr_i      = 32'd0;
        bus.wdata_i     = 32'd0;
        bus.rd_i        = 5'd0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'd0;
        #1;
        check("rst_ready", bus.req_ready_o, 1);
        check("rst_resp", bus.resp_valid_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_rd", bus.rd_o, 0);
        check("rst_err", bus.err_o, 0);
        tick();
        tick();
        rst = 1'b0;
        check("post_rst_ready", bus.req_ready_o, 1);

        // Stray ack while idle must be ignored.
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        check("idle_ack_resp", bus.resp_valid_o, 0);
        check("idle_ack_ready", bus.req_ready_o, 1);

        // Directed cases.
        do_op(1'b0, 3'd2, 32'h0000_0100, 32'd0,           5'd7,  0, 32'hDEAD_BEEF, 1'b0);
        do_op(1'b0, 3'd0, 32'h0000_0103, 32'd0,           5'd3,  0, 32'h80FF_1234, 1'b0);
        do_op(1'b0, 3'd4, 32'h0000_0103, 32'd0,           5'd4,  1, 32'h80FF_1234, 1'b0);
        do_op(1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD,   5'd0,  0, 32'd0,         1'b0);
        do_op(1'b0, 3'd2, 32'h0000_0101, 32'd0,           5'd9,  0, 32'd0,         1'b0);
        do_op(1'b0, 3'd3, 32'h0000_0100, 32'd0,           5'd10, 0, 32'd0,         1'b0);
        do_op(1'b1, 3'd4, 32'h0000_0300, 32'h1234_5678,   5'd11, 0, 32'd0,         1'b0);
        do_op(1'b0, 3'd5, 32'h0000_0402, 32'd0,           5'd12, 5, 32'h8001_7FFF, 1'b1);
        do_op(1'b1, 3'd0, 32'h0000_0501, 32'h0000_00A5,   5'd13, 5, 32'd0,         1'b1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) & 32'h2;
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)));
        end

        // Reset during an outstanding access.
        bus.req_valid_i = 1'b1;
        bus.is_store_i  = 1'b1;
        bus.funct3_i    = 3'd2;
        bus.addr_i      = 32'h0000_0600;
        bus.wdata_i     = 32'h5555_AAAA;
        bus.rd_i        = 5'd1;
        tick();
        bus.req_valid_i = 1'b0;
        check("pre_rst_req", bus.mem_req_o, 1);
        tick();
        check("pre_rst_req2", bus.mem_req_o, 1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_drops_req", bus.mem_req_o, 0);
        check("rst_drops_we", bus.mem_we_o, 0);
        check("rst_ready_mid", bus.req_ready_o, 1);
        check("rst_clears_rdata", bus.rdata_o, 0);
        check("rst_clears_rd", bus.rd_o, 0);
        tick();
        rst = 1'b0;
        bus.mem_ack_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("no_resp_after_rst", bus.resp_valid_o, 0);
            check("no_req_after_rst", bus.mem_req_o, 0);
            tick();
        end
        bus.mem_ack_i = 1'b0;

        // Access that never gets an ack.
        bus.req_valid_i = 1'b1;
        bus.is_store_i  = 1'b0;
        bus.funct3_i    = 3'd2;
        bus.addr_i      = 32'h0000_0700;
        bus.rd_i        = 5'd21;
        tick();
        bus.req_valid_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int c = 0; c < int'(TMO); c++) begin
            check("tmo_req_held", bus.mem_req_o, 1);
            check("tmo_no_resp", bus.resp_valid_o, 0);
            tick();
        end
        check("tmo_resp", bus.resp_valid_o, 1);
        check("tmo_err", bus.err_o, 1);
        check("tmo_rdata", bus.rdata_o, 0);
        check("tmo_rd", bus.rd_o, 21);
        check("tmo_req_dropped", bus.mem_req_o, 0);
        tick();
        check("tmo_idle", bus.req_ready_o, 1);
`else
        repeat (100) tick();
        check("hang_req", bus.mem_req_o, 1);
        check("hang_no_resp", bus.resp_valid_o, 0);
        check("hang_not_ready", bus.req_ready_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hang_cleared", bus.mem_req_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
